// File: rtl/surf_cmd_receiver.sv
// surf_cmd_receiver
// SURF-side decoder for the serial digitize command line from the TURF event
// generator. Each 37-bit frame carries a 2-bit buffer number and a 32-bit
// event ID. Frames are checked for odd parity and a low stop bit, and good
// frames are handed to readout logic through a valid/ack handshake.
//
// Frame on the synchronized line, one bit per clk33_i cycle:
//   start(1) | buf[1:0] MSB first | id[31:0] MSB first | P | stop(0)
//   XOR of buf, id and P must be 1.
//
// Parameters:
//   IDLE_MIN    - consecutive low cycles needed to leave RESYNC
//   SYNC_STAGES - input synchronizer depth (>= 2)
//
// Optional feature macro: CMD_RX_ERRCNT_EN
//   defined   - err_count_o counts err_o and overflow_o pulses, saturating
//   undefined - err_count_o is tied to 0
//
// Ports:
//   clk33_i      in   command clock
//   rst_n_i      in   asynchronous active-low reset
//   cmd_i        in   serial command line, idles low
//   evt_ack_i    in   consumer accepts the pending event
//   evt_valid_o  out  decoded event pending
//   evt_buffer_o out  buffer number of pending event
//   evt_id_o     out  event ID of pending event
//   overflow_o   out  pulse: good frame dropped, event still pending
//   err_o        out  pulse: parity or framing error
//   err_count_o  out  saturating error count
//
// state  | meaning
// IDLE   | waiting for a start bit
// SHIFT  | collecting buf and id bits (34 cycles)
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit and judging the frame
// RESYNC | after a framing error, waiting for IDLE_MIN quiet cycles

module surf_cmd_receiver #(
  parameter int IDLE_MIN    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk33_i,
  input  logic        rst_n_i,
  input  logic        cmd_i,
  input  logic        evt_ack_i,
  output logic        evt_valid_o,
  output logic [1:0]  evt_buffer_o,
  output logic [31:0] evt_id_o,
  output logic        overflow_o,
  output logic        err_o,
  output logic [15:0] err_count_o
);

  localparam int RW = (IDLE_MIN < 2) ? 1 : $clog2(IDLE_MIN);
  localparam logic [RW-1:0] IDLE_LAST = RW'(IDLE_MIN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_RESYNC = 3'd4
  } state_t;

  state_t              r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [33:0]         r_shift;
  logic [5:0]          r_bit_cnt;
  logic                r_par;
  logic [RW-1:0]       r_idle_cnt;
  logic                w_cmd_s;

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], cmd_i};
    end
  end

  assign w_cmd_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_idle_cnt   <= '0;
      evt_valid_o  <= 1'b0;
      evt_buffer_o <= '0;
      evt_id_o     <= '0;
      overflow_o   <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      err_o      <= 1'b0;
      overflow_o <= 1'b0;

      // An ack clears the pending event; a good frame judged in the same
      // cycle overrides this below so the consumer sees no gap.
      if (evt_valid_o && evt_ack_i) begin
        evt_valid_o <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_cmd_s) begin
            r_state   <= S_SHIFT;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
          end
        end

        S_SHIFT: begin
          r_shift   <= {r_shift[32:0], w_cmd_s};
          r_par     <= r_par ^ w_cmd_s;
          r_bit_cnt <= r_bit_cnt + 6'd1;
          if (r_bit_cnt == 6'd33) begin
            r_state <= S_PARITY;
          end
        end

        S_PARITY: begin
          r_par   <= r_par ^ w_cmd_s;
          r_state <= S_STOP;
        end

        S_STOP: begin
          if (w_cmd_s) begin
            // Framing error takes precedence; a bad parity on the same
            // frame still produces just this one pulse.
            err_o      <= 1'b1;
            r_idle_cnt <= '0;
            r_state    <= S_RESYNC;
          end else if (!r_par) begin
            err_o   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_IDLE;
            if (!evt_valid_o || evt_ack_i) begin
              evt_valid_o  <= 1'b1;
              evt_buffer_o <= r_shift[33:32];
              evt_id_o     <= r_shift[31:0];
            end else begin
              overflow_o <= 1'b1;
            end
          end
        end

        S_RESYNC: begin
          if (w_cmd_s) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == IDLE_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + RW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CMD_RX_ERRCNT_EN
  logic [15:0] r_err_cnt;

  // Counts the registered pulses, so the count lags err_o/overflow_o by
  // one cycle. The two pulses never coincide.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err_cnt <= '0;
    end else if ((err_o || overflow_o) && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_count_o = r_err_cnt;
`else
  assign err_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_surf_cmd_receiver.sv
module tb_surf_cmd_receiver;

  localparam int SYNC     = 2;
  localparam int IDLE_MIN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd = 1'b0;
  logic        man_ack = 1'b0;
  logic        auto_ack = 1'b0;
  logic        auto_mode = 1'b0;
  logic        ack_w;
  logic        evt_valid;
  logic [1:0]  evt_buffer;
  logic [31:0] evt_id;
  logic        overflow;
  logic        err;
  logic [15:0] err_count;

  assign ack_w = auto_mode ? auto_ack : man_ack;

  surf_cmd_receiver #(.IDLE_MIN(IDLE_MIN), .SYNC_STAGES(SYNC)) dut (
    .clk33_i     (clk),
    .rst_n_i     (rst_n),
    .cmd_i       (cmd),
    .evt_ack_i   (ack_w),
    .evt_valid_o (evt_valid),
    .evt_buffer_o(evt_buffer),
    .evt_id_o    (evt_id),
    .overflow_o  (overflow),
    .err_o       (err),
    .err_count_o (err_count)
  );

  always #15 clk = ~clk;

  typedef struct {
    logic [1:0]  b;
    logic [31:0] id;
  } evt_t;

  evt_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  int exp_ovf = 0;
  int exp_cnt = 0;
  int obs_err = 0;
  int obs_ovf = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int exp_errcnt();
`ifdef CMD_RX_ERRCNT_EN
    return (exp_cnt > 65535) ? 65535 : exp_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    cmd = v;
    step();
  endtask

  // Reference frame builder: parity is whatever makes the 35 payload+P bits
  // XOR to 1.
  function automatic logic [36:0] make_frame(input logic [1:0] b, input logic [31:0] id,
                                             input bit bad_par, input bit bad_stop);
    logic p;
    p = ($countones({b, id}) % 2 == 0) ? 1'b1 : 1'b0;
    if (bad_par) p = ~p;
    return {1'b1, b, id, p, bad_stop ? 1'b1 : 1'b0};
  endfunction

  task automatic send_frame(input logic [1:0] b, input logic [31:0] id,
                            input bit bad_par, input bit bad_stop);
    logic [36:0] f;
    f = make_frame(b, id, bad_par, bad_stop);
    for (int i = 36; i >= 0; i--) drive_bit(f[i]);
    cmd = 1'b0;
  endtask

  task automatic push_evt(input logic [1:0] b, input logic [31:0] id);
    evt_t e;
    e.b = b;
    e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 1;
    while (!evt_valid && lat < 60) begin
      step();
      lat++;
    end
    if (!evt_valid) check({name, "_timeout"}, 64'(evt_valid), 64'd1);
  endtask

  task automatic ack_pulse();
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted event, counts pulses and
  // checks the data hold steady while pending.
  initial begin
    logic pv;
    logic pa;
    logic [33:0] pd;
    evt_t e;
    pv = 1'b0;
    pa = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        pa = 1'b0;
      end else begin
        if (err) obs_err++;
        if (overflow) obs_ovf++;
        if (evt_valid && pv && !pa) check("data_stable", 64'({evt_buffer, evt_id}), 64'(pd));
        pa = 1'b0;
        if (evt_valid && ack_w) begin
          pa = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got id %0h, expected none", evt_id);
          end else begin
            e = exp_q.pop_front();
            check("evt_buffer", 64'(evt_buffer), 64'(e.b));
            check("evt_id", 64'(evt_id), 64'(e.id));
          end
        end
        pv = evt_valid;
        pd = {evt_buffer, evt_id};
      end
    end
  end

  // Random-latency consumer used in the randomized phase.
  initial begin
    int dly;
    dly = 0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_mode && evt_valid && !auto_ack) begin
        if (dly == 0) begin
          auto_ack = 1'b1;
          dly = $urandom_range(0, 5);
        end else begin
          dly--;
        end
      end else begin
        auto_ack = 1'b0;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [36:0] f;
    logic [1:0] rb;
    logic [31:0] rid;
    int kind;

    #5 rst_n = 1'b0;
    repeat (3) step();
    check("rst_valid", 64'(evt_valid), 64'd0);
    check("rst_buffer", 64'(evt_buffer), 64'd0);
    check("rst_id", 64'(evt_id), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_errcnt", 64'(err_count), 64'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // 1: single frame, exact latency
    push_evt(2'b10, 32'h0000_1234);
    send_frame(2'b10, 32'h0000_1234, 0, 0);
    wait_valid("t1", lat);
    check("t1_latency", 64'(lat), 64'(SYNC + 1));
    check("t1_buffer", 64'(evt_buffer), 64'd2);
    check("t1_id", 64'(evt_id), 64'h1234);
    repeat (3) step();
    check("t1_no_err", 64'(obs_err), 64'(exp_err));
    ack_pulse();
    check("t1_cleared", 64'(evt_valid), 64'd0);

    // 2: back-to-back, second frame overflows
    push_evt(2'b00, 32'd5);
    send_frame(2'b00, 32'd5, 0, 0);
    send_frame(2'b00, 32'd6, 0, 0);
    exp_ovf++;
    exp_cnt++;
    repeat (SYNC + 3) step();
    check("t2_valid", 64'(evt_valid), 64'd1);
    check("t2_id_held", 64'(evt_id), 64'd5);
    check("t2_ovf", 64'(obs_ovf), 64'(exp_ovf));
    ack_pulse();
    check("t2_cleared", 64'(evt_valid), 64'd0);
    check("t2_errcnt", 64'(err_count), 64'(exp_errcnt()));

    // 3: parity error then a good frame
    send_frame(2'b01, 32'hDEAD_BEEF, 1, 0);
    exp_err++;
    exp_cnt++;
    repeat (SYNC + 3) step();
    check("t3_err", 64'(obs_err), 64'(exp_err));
    check("t3_no_valid", 64'(evt_valid), 64'd0);
    push_evt(2'b11, 32'h0BAD_F00D);
    send_frame(2'b11, 32'h0BAD_F00D, 0, 0);
    wait_valid("t3", lat);
    check("t3_next_id", 64'(evt_id), 64'h0BAD_F00D);
    ack_pulse();

    // 4: framing error; too-short quiet time swallows a frame
    send_frame(2'b00, 32'h11, 0, 1);
    exp_err++;
    exp_cnt++;
    repeat (10) drive_bit(1'b1);
    repeat (IDLE_MIN - 1) drive_bit(1'b0);
    send_frame(2'b11, 32'hFFFF_FFFF, 0, 0);
    repeat (IDLE_MIN) drive_bit(1'b0);
    check("t4_no_decode", 64'(evt_valid), 64'd0);
    check("t4_err", 64'(obs_err), 64'(exp_err));
    push_evt(2'b00, 32'd7);
    send_frame(2'b00, 32'd7, 0, 0);
    wait_valid("t4", lat);
    check("t4_id", 64'(evt_id), 64'd7);
    ack_pulse();

    // 5: ack coincident with next stop bit
    push_evt(2'b10, 32'd8);
    send_frame(2'b10, 32'd8, 0, 0);
    wait_valid("t5a", lat);
    push_evt(2'b01, 32'd9);
    send_frame(2'b01, 32'd9, 0, 0);
    repeat (SYNC - 1) step();
    check("t5_pending8", 64'(evt_id), 64'd8);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    check("t5_no_gap", 64'(evt_valid), 64'd1);
    check("t5_id9", 64'(evt_id), 64'd9);
    step();
    check("t5_no_ovf", 64'(obs_ovf), 64'(exp_ovf));
    ack_pulse();

    // 6: reset mid-frame with an event still pending
    send_frame(2'b01, 32'h55, 0, 0);
    wait_valid("t6a", lat);
    f = make_frame(2'b10, 32'h1357_9BDF, 0, 0);
    for (int i = 36; i > 16; i--) drive_bit(f[i]);
    rst_n = 1'b0;
    cmd = 1'b0;
    step();
    check("t6_rst_valid", 64'(evt_valid), 64'd0);
    check("t6_rst_data", 64'({evt_buffer, evt_id}), 64'd0);
    check("t6_rst_pulses", 64'({overflow, err}), 64'd0);
    check("t6_rst_errcnt", 64'(err_count), 64'd0);
    step();
    rst_n = 1'b1;
    exp_cnt = 0;
    repeat (3) step();
    check("t6_post_valid", 64'(evt_valid), 64'd0);
    push_evt(2'b11, 32'hFFFF_FFFF);
    send_frame(2'b11, 32'hFFFF_FFFF, 0, 0);
    wait_valid("t6", lat);
    check("t6_buffer", 64'(evt_buffer), 64'd3);
    check("t6_id", 64'(evt_id), 64'hFFFF_FFFF);
    ack_pulse();
    check("t6_errcnt", 64'(err_count), 64'd0);

    // Randomized traffic with a random-latency consumer
    auto_mode = 1'b1;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      rb = 2'($urandom);
      rid = $urandom;
      repeat ($urandom_range(0, 3)) drive_bit(1'b0);
      if (kind == 0) begin
        send_frame(rb, rid, 1, 0);
        exp_err++;
        exp_cnt++;
      end else if (kind == 1) begin
        send_frame(rb, rid, $urandom_range(0, 1), 1);
        exp_err++;
        exp_cnt++;
        repeat ($urandom_range(0, 5)) drive_bit(1'b1);
        repeat ($urandom_range(IDLE_MIN, IDLE_MIN + 2)) drive_bit(1'b0);
      end else begin
        push_evt(rb, rid);
        send_frame(rb, rid, 0, 0);
      end
    end
    lat = 0;
    while (exp_q.size() != 0 && lat < 200) begin
      step();
      lat++;
    end
    repeat (10) step();
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_err", 64'(obs_err), 64'(exp_err));
    check("rand_ovf", 64'(obs_ovf), 64'(exp_ovf));
    check("rand_errcnt", 64'(err_count), 64'(exp_errcnt()));
    check("rand_idle", 64'(evt_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
